vram_line_scheduler: RTL and testbench

//  Owns the single VRAM port and shares it between the per-line display fetch and NREQ generic requesters.

---
 rtl/vdp_pkg.sv | 15 +
 rtl/vram_line_scheduler_arbiter.sv | 34 +++
 rtl/vram_line_scheduler.sv | 164 ++++++++++++++++
 tb/tb_vram_line_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_pkg.sv
// Shared video-pipeline definitions: display timing, VRAM geometry and the
// state type of the per-line fetch FSM.
package vdp_pkg;
    localparam int HA_END  = 1279;
    localparam int LINE    = 1649;
    localparam int VA_END  = 719;
    localparam int SCREEN  = 749;
    localparam int VRAM_AW = 16;
    localparam int VRAM_DW = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/vram_line_scheduler_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the
// pointer, and the pointer value that follows that grant.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_next_ptr
);

    logic          w_found;
    logic [PW-1:0] w_idx;

    // Scan from the pointer, wrapping, and take the first request found.
    always_comb begin
        o_grant    = '0;
        o_next_ptr = i_ptr;
        w_found    = 1'b0;
        w_idx      = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = PW'((int'(i_ptr) + k) % N);
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_next_ptr     = PW'((int'(w_idx) + 1) % N);
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/vram_line_scheduler.sv
// Owner of the single VRAM port: the per-line display fetch has absolute
// priority, every spare cycle is shared round-robin among NREQ requesters.
module vram_line_scheduler
    import vdp_pkg::*;
#(
    parameter  int CORDW       = 11,
    parameter  int NREQ        = 4,
    parameter  int AW          = VRAM_AW,
    parameter  int DW          = VRAM_DW,
    parameter  int FETCH_WORDS = 160,
    parameter  int FETCH_BASE  = 0,
    parameter  int VA_END      = vdp_pkg::VA_END,
    localparam int LBW         = (FETCH_WORDS > 1) ? $clog2(FETCH_WORDS) : 1,
    localparam int PW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk_pix,
    input  logic               rst_pix,
    input  logic               line,
    input  logic               frame,
    input  logic [CORDW-1:0]   sy_plus1,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic               mem_en,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata,
    output logic               lb_we,
    output logic [LBW-1:0]     lb_addr,
    output logic [DW-1:0]      lb_wdata,
    output logic               fetch_busy,
    output logic               fetch_overrun
);

    fetch_state_t    r_state;
    logic [AW-1:0]   r_row;
    logic [LBW-1:0]  r_widx;
    logic [PW-1:0]   r_ptr;
    logic            r_lb_we;
    logic [LBW-1:0]  r_lb_addr;
    logic [NREQ-1:0] r_rsp_valid;
    logic            r_overrun;

    logic            w_free;
    logic            w_start;
    logic            w_last;
    logic [AW-1:0]   w_new_row;
    logic [NREQ-1:0] w_req;
    logic [NREQ-1:0] w_grant;
    logic [PW-1:0]   w_next_ptr;
    logic            w_gnt_we;
    logic [AW-1:0]   w_gnt_addr;
    logic [DW-1:0]   w_gnt_wdata;

    // Requesters only see the port when no fetch word is issued; reset masks grants too.
    assign w_free    = (r_state == IDLE) && !rst_pix;
    assign w_req     = req_valid & {NREQ{w_free}};
    assign w_start   = line && (sy_plus1 <= CORDW'(VA_END));
    assign w_last    = (r_widx == LBW'(FETCH_WORDS - 1));
    assign w_new_row = AW'(FETCH_BASE) + AW'(sy_plus1) * AW'(FETCH_WORDS);

    rr_arbiter #(.N(NREQ)) u_arb (
        .i_req      (w_req),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_next_ptr (w_next_ptr)
    );

    // Select the winning requester's command fields.
    always_comb begin
        w_gnt_we    = 1'b0;
        w_gnt_addr  = '0;
        w_gnt_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_gnt_we    = req_we[i];
                w_gnt_addr  = req_addr[i*AW +: AW];
                w_gnt_wdata = req_wdata[i*DW +: DW];
            end else begin
                w_gnt_we = w_gnt_we;
            end
        end
    end

    assign req_ready     = w_grant;
    assign fetch_busy    = (r_state == FETCH);
    assign mem_en        = fetch_busy || (|w_grant);
    assign mem_we        = fetch_busy ? 1'b0 : w_gnt_we;
    assign mem_addr      = fetch_busy ? (r_row + AW'(r_widx)) : w_gnt_addr;
    assign mem_wdata     = fetch_busy ? '0 : w_gnt_wdata;
    assign lb_we         = r_lb_we;
    assign lb_addr       = r_lb_addr;
    assign lb_wdata      = r_lb_we ? mem_rdata : '0;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_data      = (|r_rsp_valid) ? mem_rdata : '0;
    assign fetch_overrun = r_overrun;

    // Fetch FSM: a line pulse (re)starts a row, then one word per cycle until the last.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_state   <= IDLE;
            r_row     <= '0;
            r_widx    <= '0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= FETCH;
                        r_row   <= w_new_row;
                        r_widx  <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                FETCH: begin
                    if (line) begin
                        r_state <= w_start ? FETCH : IDLE;
                        r_row   <= w_new_row;
                        r_widx  <= '0;
                    end else if (w_last) begin
                        r_state <= IDLE;
                        r_widx  <= '0;
                    end else begin
                        r_widx  <= r_widx + LBW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_widx  <= '0;
                end
            endcase
            // A pulse on the last-word cycle is a clean hand-over, not an overrun.
            if (fetch_busy && line && !w_last) begin
                r_overrun <= 1'b1;
            end else if (frame) begin
                r_overrun <= 1'b0;
            end else begin
                r_overrun <= r_overrun;
            end
        end
    end

    // Read strobes trail each issued read by one cycle; reset drops anything in flight.
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            r_lb_we     <= 1'b0;
            r_lb_addr   <= '0;
            r_rsp_valid <= '0;
            r_ptr       <= '0;
        end else begin
            r_lb_we     <= fetch_busy;
            r_lb_addr   <= fetch_busy ? r_widx : '0;
            r_rsp_valid <= w_grant & {NREQ{~w_gnt_we}};
            r_ptr       <= w_next_ptr;
        end
    end

endmodule

// File: tb/tb_vram_line_scheduler.sv
// Self-checking bench for vram_line_scheduler: hand sequences, an arbitration
// vector table and a randomized run, all checked by a queue-based model.
module tb_vram_line_scheduler;
    localparam int NREQ  = 4;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int FW    = 160;
    localparam int CORDW = 11;
    localparam int LBW   = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               line = 1'b0;
    logic               frame = 1'b0;
    logic [CORDW-1:0]   sy = '0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_we = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]      rsp_data, mem_wdata, lb_wdata;
    logic               mem_en, mem_we, lb_we, fetch_busy, fetch_overrun;
    logic [AW-1:0]      mem_addr;
    logic [LBW-1:0]     lb_addr;
    logic [DW-1:0]      rdata_q;
    logic [DW-1:0]      vram [0:65535];

    vram_line_scheduler dut (
        .clk_pix(clk), .rst_pix(rst), .line(line), .frame(frame), .sy_plus1(sy),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(rdata_q), .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
        .fetch_busy(fetch_busy), .fetch_overrun(fetch_overrun)
    );

    always #5 clk = ~clk;

    // Single-port VRAM with one-cycle read latency; refilled with a pattern in reset.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 65536; i++) vram[i] <= DW'(i * 7) ^ 16'h5A5A;
        end else if (mem_en) begin
            if (mem_we) vram[mem_addr] <= mem_wdata;
            else rdata_q <= vram[mem_addr];
        end
    end

    typedef struct { int addr; int idx; } fword_t;
    typedef struct { logic [3:0] v; logic [3:0] rdy; } arb_vec_t;

    fword_t          fq[$];
    int              m_ptr, p_rsp, p_rsp_data, p_lb_idx, p_lb_data;
    bit              m_ovr, p_lb;
    logic [NREQ-1:0] last_ready;
    int              n_tests = 0;
    int              n_fail = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void m_reset();
        fq.delete();
        m_ptr = 0; m_ovr = 0; p_lb = 0; p_rsp = -1; last_ready = '0;
    endfunction

    // Model: pending fetch words form a queue; an empty queue frees the port for round-robin.
    function automatic void model_cycle();
        int  w;
        bit  busy;
        bit  ovr_set;
        logic [NREQ-1:0] er;
        busy = (fq.size() > 0);
        w = -1;
        er = '0;
        chk("fetch_busy", fetch_busy, busy);
        chk("fetch_overrun", fetch_overrun, m_ovr);
        chk("lb_we", lb_we, p_lb);
        if (p_lb) begin
            chk("lb_addr", lb_addr, p_lb_idx);
            chk("lb_wdata", lb_wdata, p_lb_data);
        end
        chk("rsp_valid", rsp_valid, (p_rsp >= 0) ? (1 << p_rsp) : 0);
        if (p_rsp >= 0) chk("rsp_data", rsp_data, p_rsp_data);
        if (!busy) begin
            for (int k = 0; k < NREQ; k++) begin
                int j = (m_ptr + k) % NREQ;
                if (w < 0 && req_valid[j]) w = j;
            end
        end
        if (w >= 0) er[w] = 1'b1;
        chk("req_ready", req_ready, er);
        chk("mem_en", mem_en, busy || (w >= 0));
        last_ready = req_ready;
        p_lb = 0;
        p_rsp = -1;
        if (busy) begin
            chk("fetch_mem_we", mem_we, 0);
            chk("fetch_mem_addr", mem_addr, fq[0].addr);
            p_lb = 1;
            p_lb_idx = fq[0].idx;
            p_lb_data = vram[fq[0].addr];
            void'(fq.pop_front());
        end else if (w >= 0) begin
            chk("req_mem_we", mem_we, req_we[w]);
            chk("req_mem_addr", mem_addr, req_addr[w*AW +: AW]);
            if (req_we[w]) begin
                chk("req_mem_wdata", mem_wdata, req_wdata[w*DW +: DW]);
            end else begin
                p_rsp = w;
                p_rsp_data = vram[req_addr[w*AW +: AW]];
            end
            m_ptr = (w + 1) % NREQ;
        end
        ovr_set = line && (fq.size() > 0);
        if (line) begin
            fq.delete();
            if (sy <= 719)
                for (int k = 0; k < FW; k++) fq.push_back('{(int'(sy) * FW + k) % 65536, k});
        end
        if (ovr_set) m_ovr = 1;
        else if (frame) m_ovr = 0;
    endfunction

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_fetch_busy"}, fetch_busy, 0);
        chk({tag, "_overrun"}, fetch_overrun, 0);
        chk({tag, "_lb_we"}, lb_we, 0);
        chk({tag, "_lb_addr"}, lb_addr, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_req_ready"}, req_ready, 0);
    endtask

    arb_vec_t tbl [11];
    int       n;

    initial begin
        tbl[0]  = '{4'b1111, 4'b0001};
        tbl[1]  = '{4'b1111, 4'b0010};
        tbl[2]  = '{4'b1111, 4'b0100};
        tbl[3]  = '{4'b1111, 4'b1000};
        tbl[4]  = '{4'b1111, 4'b0001};
        tbl[5]  = '{4'b0001, 4'b0001};
        tbl[6]  = '{4'b0000, 4'b0000};
        tbl[7]  = '{4'b1001, 4'b1000};
        tbl[8]  = '{4'b0110, 4'b0010};
        tbl[9]  = '{4'b0110, 4'b0100};
        tbl[10] = '{4'b0011, 4'b0001};
        for (int i = 0; i < NREQ; i++) req_addr[i*AW +: AW] = AW'(16'h2000 + i * 17);

        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        m_reset();
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        // Single line for row 5: reads 800..959, line buffer one cycle behind.
        sy = 11'd5; line = 1'b1; step(); line = 1'b0;
        chk("A_first_addr", mem_addr, 800);
        repeat (FW) step();
        chk("A_busy_after", fetch_busy, 0);
        chk("A_lb_last", lb_addr, 159);
        step();

        // Round-robin table with an idle FSM; responses checked by the model.
        req_we = '0;
        for (int i = 0; i < 11; i++) begin
            req_valid = tbl[i].v;
            #1 chk("arb_table_ready", req_ready, tbl[i].rdy);
            step();
        end
        req_valid = '0; step();

        // Requester 2 stalls for the whole fetch, then wins the first free cycle.
        sy = 11'd3; line = 1'b1; step(); line = 1'b0;
        req_valid = 4'b0100;
        n = 0;
        while (n < 400) begin
            #1;
            if (req_ready[2]) break;
            step();
            n++;
        end
        chk("C_wait_cycles", n, 160);
        step(); req_valid = '0; step();

        // Line pulse mid-fetch: overrun, restart at the new row, cleared by frame.
        sy = 11'd10; line = 1'b1; step(); line = 1'b0;
        repeat (100) step();
        chk("D_addr_w100", mem_addr, 1700);
        sy = 11'd11; line = 1'b1; step(); line = 1'b0;
        chk("D_overrun", fetch_overrun, 1);
        chk("D_restart", mem_addr, 1760);
        repeat (5) step();
        frame = 1'b1; step(); frame = 1'b0;
        chk("D_overrun_clr", fetch_overrun, 0);
        repeat (FW) step();

        // Line on the last-word cycle: seamless hand-over, no overrun.
        sy = 11'd1; line = 1'b1; step(); line = 1'b0;
        repeat (FW - 1) step();
        chk("E_last_addr", mem_addr, 319);
        sy = 11'd2; line = 1'b1; step(); line = 1'b0;
        chk("E_no_overrun", fetch_overrun, 0);
        chk("E_next_row", mem_addr, 320);
        repeat (FW + 1) step();

        // Line beyond the visible area: no fetch, requesters served every cycle.
        sy = 11'd720; line = 1'b1; req_valid = 4'b1111; step(); line = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1 chk("F_served", mem_en, 1);
            chk("F_idle", fetch_busy, 0);
            step();
        end
        req_valid = '0; step();

        // Reset mid-fetch with a read in flight.
        sy = 11'd4; line = 1'b1; step(); line = 1'b0;
        repeat (20) step();
        rst = 1'b1;
        #1 check_all_zero("G_rst");
        m_reset();
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) step();

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            line  = ($urandom_range(0, 119) == 0);
            frame = ($urandom_range(0, 299) == 0);
            sy = ($urandom_range(0, 9) == 0) ? CORDW'($urandom_range(700, 2047))
                                             : CORDW'($urandom_range(0, 719));
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && last_ready[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_we[i] = 1'($urandom);
                    req_addr[i*AW +: AW] = AW'($urandom);
                    req_wdata[i*DW +: DW] = DW'($urandom);
                end
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
